// File: rtl/ram_block_mover.sv
// ram_block_mover: bus initiator for a 256 x 32-bit RAM that copies or fills a
// block of words, one word at a time, and pulses done when the block is complete.
module ram_block_mover #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [7:0]  src_adr,
   input  logic [7:0]  dst_adr,
   input  logic [8:0]  len,
   input  logic [31:0] fill_data,
   output logic        busy,
   output logic        done,
   output logic [8:0]  xfer_cnt,
   output logic [7:0]  mem_adr,
   output logic [31:0] mem_din,
   output logic        mem_wr,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

   // Last READ cycle index; the READ state lasts LatMax+1 cycles.
   localparam logic [1:0] LatMax = RD_LAT[1:0];

   state_e      state_q;
   logic        mode_q;
   logic [7:0]  src_q;
   logic [7:0]  dst_q;
   logic [8:0]  rem_q;
   logic [31:0] fill_q;
   logic [1:0]  lat_q;

   // Single FSM; every output is registered and set on the edge entering its state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         src_q    <= 8'd0;
         dst_q    <= 8'd0;
         rem_q    <= 9'd0;
         fill_q   <= 32'd0;
         lat_q    <= 2'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         xfer_cnt <= 9'd0;
         mem_adr  <= 8'd0;
         mem_din  <= 32'd0;
         mem_wr   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               mem_wr <= 1'b0;
               busy   <= 1'b0;
               if (start) begin
                  mode_q   <= mode;
                  src_q    <= src_adr;
                  dst_q    <= dst_adr;
                  rem_q    <= len;
                  fill_q   <= fill_data;
                  xfer_cnt <= 9'd0;
                  lat_q    <= 2'd0;
                  if (len == 9'd0) begin
                     state_q <= StFin;
                     done    <= 1'b1;
                  end else if (mode) begin
                     state_q <= StWrite;
                     busy    <= 1'b1;
                     mem_wr  <= 1'b1;
                     mem_adr <= dst_adr;
                     mem_din <= fill_data;
                  end else begin
                     state_q <= StRead;
                     busy    <= 1'b1;
                     mem_adr <= src_adr;
                  end
               end
            end
            StRead: begin
               if (lat_q == LatMax) begin
                  // Read data is valid on this edge; hand it straight to the write.
                  lat_q   <= 2'd0;
                  mem_din <= mem_dout;
                  mem_adr <= dst_q;
                  mem_wr  <= 1'b1;
                  state_q <= StWrite;
               end else begin
                  lat_q <= lat_q + 2'd1;
               end
            end
            StWrite: begin
               xfer_cnt <= xfer_cnt + 9'd1;
               src_q    <= src_q + 8'd1;
               dst_q    <= dst_q + 8'd1;
               rem_q    <= rem_q - 9'd1;
               if (rem_q == 9'd1) begin
                  state_q <= StFin;
                  mem_wr  <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (mode_q) begin
                  mem_wr  <= 1'b1;
                  mem_adr <= dst_q + 8'd1;
                  mem_din <= fill_q;
               end else begin
                  state_q <= StRead;
                  mem_wr  <= 1'b0;
                  mem_adr <= src_q + 8'd1;
               end
            end
            StFin: begin
               mem_wr  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover with a 1-cycle registered-read RAM model.
module tb_ram_block_mover;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  src_adr = 8'd0;
   logic [7:0]  dst_adr = 8'd0;
   logic [8:0]  len = 9'd0;
   logic [31:0] fill_data = 32'd0;
   logic        busy, done;
   logic [8:0]  xfer_cnt;
   logic [7:0]  mem_adr;
   logic [31:0] mem_din;
   logic        mem_wr;
   logic [31:0] mem_dout;

   ram_block_mover #(.RD_LAT(1)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .src_adr(src_adr), .dst_adr(dst_adr), .len(len), .fill_data(fill_data),
      .busy(busy), .done(done), .xfer_cnt(xfer_cnt), .mem_adr(mem_adr),
      .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout)
   );

   always #5 clock = ~clock;

   // RAM model with one cycle of read latency and a bench-side preload port
   logic [31:0] ram [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_adr = 8'd0;
   logic [31:0] pre_dat = 32'd0;
   always @(posedge clock) begin
      if (mem_wr) ram[mem_adr] <= mem_din;
      else if (pre_we) ram[pre_adr] <= pre_dat;
      mem_dout <= ram[mem_adr];
   end

   // Cumulative protocol monitor, sampled on the falling edge
   int wr_count = 0, busy_cycles = 0, done_count = 0, proto_err = 0, rd_run = 0;
   always @(negedge clock) begin
      if (mem_wr) wr_count <= wr_count + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (done) done_count <= done_count + 1;
      if ((mem_wr && !busy) || (busy && done)) proto_err <= proto_err + 1;
      // every COPY write must follow exactly two READ cycles
      if (mem_wr && !dut.mode_q && rd_run != 2) proto_err <= proto_err + 1;
      if (busy && !mem_wr) rd_run <= rd_run + 1;
      else rd_run <= 0;
   end

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clock);
      pre_we = 1'b1; pre_adr = a; pre_dat = d;
      @(negedge clock);
      pre_we = 1'b0;
   endtask

   // Issues one operation; cyc counts cycles from start (cycle 1) to done, -1 on timeout
   task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] l, input logic [31:0] f, output int cyc);
      @(negedge clock);
      mode = m; src_adr = s; dst_adr = d; len = l; fill_data = f; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 2;
      while (!done && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   typedef struct {
      logic             mode;
      logic [7:0]       src;
      logic [7:0]       dst;
      logic [8:0]       len;
      logic [31:0]      fill;
      int               n_pre;
      logic [2:0][7:0]  pre_adr;
      logic [2:0][31:0] pre_val;
      int               n_chk;
      logic [2:0][7:0]  chk_adr;
      logic [2:0][31:0] chk_val;
      int               exp_cycles;
      int               exp_xfer;
      int               exp_wr;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int cyc, wr0, busy0, err0, done0;

      // FILL len 4 at 0x10, 0x14 must survive
      vecs[0] = '{1'b1, 8'h00, 8'h10, 9'd4, 32'hDEADBEEF,
                  1, {8'h00, 8'h00, 8'h14}, {32'h0, 32'h0, 32'h0BADF00D},
                  3, {8'h14, 8'h13, 8'h10}, {32'h0BADF00D, 32'hDEADBEEF, 32'hDEADBEEF},
                  6, 4, 4};
      // COPY 0x00..0x02 -> 0x80..0x82
      vecs[1] = '{1'b0, 8'h00, 8'h80, 9'd3, 32'h0,
                  3, {8'h02, 8'h01, 8'h00}, {32'h33333333, 32'h22222222, 32'h11111111},
                  3, {8'h82, 8'h81, 8'h80}, {32'h33333333, 32'h22222222, 32'h11111111},
                  11, 3, 3};
      // FILL wrapping 0xFE, 0xFF, 0x00; 0x01 untouched
      vecs[2] = '{1'b1, 8'h00, 8'hFE, 9'd3, 32'h5A5A5A5A,
                  1, {8'h00, 8'h00, 8'h01}, {32'h0, 32'h0, 32'hCAFEF00D},
                  3, {8'h01, 8'h00, 8'hFE}, {32'hCAFEF00D, 32'h5A5A5A5A, 32'h5A5A5A5A},
                  5, 3, 3};
      // len 0 FILL
      vecs[3] = '{1'b1, 8'h00, 8'h20, 9'd0, 32'hFFFFFFFF,
                  1, {8'h00, 8'h00, 8'h20}, {32'h0, 32'h0, 32'h12345678},
                  1, {8'h00, 8'h00, 8'h20}, {32'h0, 32'h0, 32'h12345678},
                  2, 0, 0};
      // len 0 COPY
      vecs[4] = '{1'b0, 8'h00, 8'h30, 9'd0, 32'h0,
                  1, {8'h00, 8'h00, 8'h30}, {32'h0, 32'h0, 32'h9ABCDEF0},
                  1, {8'h00, 8'h00, 8'h30}, {32'h0, 32'h0, 32'h9ABCDEF0},
                  2, 0, 0};
      // overlapping COPY 0x40 -> 0x41 replicates A
      vecs[5] = '{1'b0, 8'h40, 8'h41, 9'd3, 32'h0,
                  3, {8'h43, 8'h41, 8'h40}, {32'h0, 32'hBBBB0002, 32'hAAAA0001},
                  3, {8'h43, 8'h42, 8'h41}, {32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001},
                  11, 3, 3};

      repeat (3) @(negedge clock);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset xfer_cnt", {23'd0, xfer_cnt}, 32'd0);
      check("reset mem_wr", {31'd0, mem_wr}, 32'd0);
      check("reset mem_adr", {24'd0, mem_adr}, 32'd0);
      check("reset mem_din", mem_din, 32'd0);
      reset = 1'b0;

      for (int v = 0; v < 6; v++) begin
         for (int p = 0; p < vecs[v].n_pre; p++)
            preload(vecs[v].pre_adr[p], vecs[v].pre_val[p]);
         wr0 = wr_count; busy0 = busy_cycles; err0 = proto_err;
         run_op(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, cyc);
         check($sformatf("v%0d cycles to done", v), cyc, vecs[v].exp_cycles);
         check($sformatf("v%0d xfer_cnt", v), {23'd0, xfer_cnt}, vecs[v].exp_xfer);
         @(negedge clock);
         check($sformatf("v%0d done one pulse", v), {31'd0, done}, 32'd0);
         check($sformatf("v%0d write count", v), wr_count - wr0, vecs[v].exp_wr);
         check($sformatf("v%0d busy cycles", v), busy_cycles - busy0,
               vecs[v].exp_cycles - 2);
         check($sformatf("v%0d protocol", v), proto_err - err0, 32'd0);
         check($sformatf("v%0d xfer_cnt holds", v), {23'd0, xfer_cnt}, vecs[v].exp_xfer);
         for (int c = 0; c < vecs[v].n_chk; c++)
            check($sformatf("v%0d ram[%0h]", v, vecs[v].chk_adr[c]),
                  ram[vecs[v].chk_adr[c]], vecs[v].chk_val[c]);
      end

      // Reset during the third WRITE of a len 8 FILL
      preload(8'h63, 32'hFACEFACE);
      done0 = done_count;
      @(negedge clock);
      mode = 1'b1; dst_adr = 8'h60; len = 9'd8; fill_data = 32'h77777777; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      check("mid third write mem_wr", {31'd0, mem_wr}, 32'd1);
      check("mid third write mem_adr", {24'd0, mem_adr}, 32'h62);
      check("mid third write xfer_cnt", {23'd0, xfer_cnt}, 32'd2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("after reset mem_wr", {31'd0, mem_wr}, 32'd0);
      check("after reset busy", {31'd0, busy}, 32'd0);
      check("after reset xfer_cnt", {23'd0, xfer_cnt}, 32'd0);
      wr0 = wr_count;
      repeat (12) @(negedge clock);
      check("after reset no done", done_count - done0, 32'd0);
      check("after reset no writes", wr_count - wr0, 32'd0);
      check("interrupted ram[62]", ram[8'h62], 32'h77777777);
      check("interrupted ram[63]", ram[8'h63], 32'hFACEFACE);

      // Fresh FILL, with a start issued while busy that must be ignored
      preload(8'h72, 32'h0F0F0F0F);
      @(negedge clock);
      mode = 1'b1; dst_adr = 8'h70; len = 9'd2; fill_data = 32'h13579BDF; start = 1'b1;
      @(negedge clock);
      mode = 1'b0; src_adr = 8'h00; dst_adr = 8'h90; len = 9'd5;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("fresh fill done at cycle 4", {31'd0, done}, 32'd1);
      check("fresh fill xfer_cnt", {23'd0, xfer_cnt}, 32'd2);
      check("fresh fill ram[70]", ram[8'h70], 32'h13579BDF);
      check("fresh fill ram[71]", ram[8'h71], 32'h13579BDF);
      wr0 = wr_count; busy0 = busy_cycles;
      repeat (10) @(negedge clock);
      check("busy start not queued writes", wr_count - wr0, 32'd0);
      check("busy start not queued busy", busy_cycles - busy0, 32'd0);
      check("fresh fill ram[72]", ram[8'h72], 32'h0F0F0F0F);
      check("final protocol", proto_err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
